// File: rtl/sid_i2s_out_pkg.sv
// Shared types and helpers for the SID I2S output stage.
// Frames are built left-aligned in a fixed 64-bit image so any legal slot width fits.
package sid_i2s_out_pkg;

  localparam int unsigned SAMPLE_BITS       = 24;
  localparam int unsigned SLOT_BITS_DEFAULT = 32;
  localparam int unsigned SLOT_BITS_MAX     = 32;
  localparam int unsigned FRAME_BITS_MAX    = 2 * SLOT_BITS_MAX;

  typedef logic signed [SAMPLE_BITS-1:0] i2s_bits_t;

  typedef struct packed {
    i2s_bits_t left;
    i2s_bits_t right;
  } audio_t;

  typedef logic [FRAME_BITS_MAX-1:0] frame_t;

  // Left slot occupies the top slot_bits bits and the right slot the next slot_bits.
  // Unused low bits stay zero.
  function automatic frame_t frame_image(audio_t a, int unsigned slot_bits);
    frame_t left_img;
    frame_t right_img;
    left_img  = {a.left,  {(FRAME_BITS_MAX-SAMPLE_BITS){1'b0}}};
    right_img = {a.right, {(FRAME_BITS_MAX-SAMPLE_BITS){1'b0}}} >> slot_bits;
    return left_img | right_img;
  endfunction

endpackage

// File: rtl/sid_i2s_clkgen.sv
// I2S master timing: SCLK divider, per-frame bit counter and LRCLK.
// fall_o marks the clk cycle whose edge drives SCLK from 1 to 0.
module sid_i2s_clkgen #(
  parameter int unsigned BCLK_DIV  = 4,
  parameter int unsigned SLOT_BITS = 32
) (
  input  logic       clk,
  input  logic       rst,
  output logic       sclk_o,
  output logic       lrclk_o,
  output logic       fall_o,
  output logic [5:0] bit_cnt_o
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(2 * SLOT_BITS - 1);
  localparam logic [5:0] SLOT_W   = 6'(SLOT_BITS);

  logic [7:0] div_cnt_q, div_cnt_d;
  logic [5:0] bit_cnt_q, bit_cnt_d;
  logic       sclk_q, sclk_d;
  logic       lrclk_q, lrclk_d;
  logic       wrap;
  logic       fall;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    wrap      = (div_cnt_q == DIV_LAST);
    fall      = wrap && sclk_q;
    div_cnt_d = wrap ? 8'd0 : div_cnt_q + 8'd1;
    sclk_d    = wrap ? ~sclk_q : sclk_q;
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    if (fall) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? 6'd0 : bit_cnt_q + 6'd1;
      lrclk_d   = (bit_cnt_d >= SLOT_W);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      lrclk_q   <= lrclk_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign lrclk_o   = lrclk_q;
  assign fall_o    = fall;
  assign bit_cnt_o = bit_cnt_q;

endmodule

// File: rtl/sid_i2s_out.sv
// SID audio to Philips I2S serializer: sample-and-hold capture, frame load,
// one-bit-delayed MSB-first shifting. The block is the I2S master.
module sid_i2s_out
  import sid_i2s_out_pkg::*;
#(
  parameter int unsigned BCLK_DIV  = 4,
  parameter int unsigned SLOT_BITS = SLOT_BITS_DEFAULT
) (
  input  logic   clk,
  input  logic   rst,
  input  audio_t audio_i,
  input  logic   audio_valid,
  input  logic   mute,
  output logic   i2s_sclk,
  output logic   i2s_lrclk,
  output logic   i2s_dout,
  output logic   frame_load,
  output logic   stale
);

  localparam logic [5:0] BIT_LAST = 6'(2 * SLOT_BITS - 1);

  logic       fall;
  logic [5:0] bit_cnt;
  logic       frame_start;

  audio_t hold_q, hold_d;
  frame_t shift_q, shift_d;
  frame_t load_img;
  logic   fresh_q, fresh_d;
  logic   delay_q, delay_d;
  logic   dout_q, dout_d;
  logic   frame_load_q, frame_load_d;
  logic   stale_q, stale_d;

  sid_i2s_clkgen #(
    .BCLK_DIV  (BCLK_DIV),
    .SLOT_BITS (SLOT_BITS)
  ) u_clkgen (
    .clk       (clk),
    .rst       (rst),
    .sclk_o    (i2s_sclk),
    .lrclk_o   (i2s_lrclk),
    .fall_o    (fall),
    .bit_cnt_o (bit_cnt)
  );

  assign frame_start = fall && (bit_cnt == BIT_LAST);

  // A load places the new image and shifts it in the same fall event, so the
  // delay flop holds the left MSB and it reaches i2s_dout one SCLK later.
  assign load_img = frame_start ? (mute ? '0 : frame_image(hold_q, SLOT_BITS)) : shift_q;

  always_comb begin
    hold_d       = hold_q;
    fresh_d      = fresh_q;
    shift_d      = shift_q;
    delay_d      = delay_q;
    dout_d       = dout_q;
    stale_d      = stale_q;
    frame_load_d = frame_start;
    if (fall) begin
      dout_d  = delay_q;
      delay_d = load_img[FRAME_BITS_MAX-1];
      shift_d = load_img << 1;
    end
    if (frame_start) begin
      stale_d = ~fresh_q;
      fresh_d = 1'b0;
    end
    // Applied last: a strobe colliding with a load is kept for the next frame.
    if (audio_valid) begin
      hold_d  = audio_i;
      fresh_d = 1'b1;
    end
  end

  // NOTE: the hold register is reset too, so the first frame after reset is silence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      fresh_q      <= 1'b0;
      shift_q      <= '0;
      delay_q      <= 1'b0;
      dout_q       <= 1'b0;
      frame_load_q <= 1'b0;
      stale_q      <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      fresh_q      <= fresh_d;
      shift_q      <= shift_d;
      delay_q      <= delay_d;
      dout_q       <= dout_d;
      frame_load_q <= frame_load_d;
      stale_q      <= stale_d;
    end
  end

  assign i2s_dout   = dout_q;
  assign frame_load = frame_load_q;
  assign stale      = stale_q;

endmodule

// File: tb/tb_sid_i2s_out.sv
// Self-checking bench for sid_i2s_out (BCLK_DIV=2, SLOT_BITS=32): cycle-indexed
// frame model compared every clock, plus literal expectations for key scenarios.
module tb_sid_i2s_out;
  import sid_i2s_out_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  audio_t audio = '0;
  logic   audio_valid = 1'b0;
  logic   mute = 1'b0;
  logic   i2s_sclk, i2s_lrclk, i2s_dout, frame_load, stale;

  int n_checks = 0;
  int n_errors = 0;

  sid_i2s_out #(.BCLK_DIV(2), .SLOT_BITS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .audio_i     (audio),
    .audio_valid (audio_valid),
    .mute        (mute),
    .i2s_sclk    (i2s_sclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_dout    (i2s_dout),
    .frame_load  (frame_load),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: cyc counts clk edges since reset release. SCLK half period = 2 clk,
  // one bit = 4 clk, one frame = 64 bits = 256 clk. img_m[k] is the frame loaded
  // at cycle 256*k; frame 0 is the silent frame implied by reset.
  int          cyc = 0;
  logic [23:0] hold_l_m = '0, hold_r_m = '0;
  logic        fresh_m = 1'b0, stale_m = 1'b0;
  logic [63:0] img_m [0:255];

  always begin
    int e, k, j;
    logic exp_dout;
    @(posedge clk);
    if (rst) begin
      cyc = 0; hold_l_m = '0; hold_r_m = '0; fresh_m = 1'b0; stale_m = 1'b0;
      for (int i = 0; i < 256; i++) img_m[i] = '0;
    end else begin
      cyc++;
      if (cyc % 256 == 0) begin
        img_m[(cyc / 256) % 256] = mute ? 64'd0 : {hold_l_m, 8'h00, hold_r_m, 8'h00};
        stale_m = !fresh_m;
        fresh_m = 1'b0;
      end
      if (audio_valid) begin
        hold_l_m = audio.left;
        hold_r_m = audio.right;
        fresh_m  = 1'b1;
      end
      #1;
      if (!rst) begin
        e = cyc / 4;
        if (e == 0) exp_dout = 1'b0;
        else begin
          k = (e - 1) / 64;
          j = (e - 1) % 64;
          exp_dout = img_m[k % 256][63 - j];
        end
        check("sclk",       64'(i2s_sclk),   64'((cyc / 2) % 2));
        check("lrclk",      64'(i2s_lrclk),  64'(((cyc / 4) % 64) >= 32));
        check("frame_load", 64'(frame_load), 64'(cyc > 0 && cyc % 256 == 0));
        check("dout",       64'(i2s_dout),   64'(exp_dout));
        check("stale",      64'(stale),      64'(stale_m));
      end
    end
  end

  // Returns at the negedge following clk edge n (counted from reset release).
  task automatic wait_cycle(input int n);
    for (int guard = 0; guard < 20000; guard++) begin
      @(negedge clk);
      if (cyc >= n) return;
    end
    check("wait_cycle_timeout", 64'(cyc), 64'(n));
  endtask

  task automatic strobe(input logic [23:0] l, input logic [23:0] r);
    audio.left  = l;
    audio.right = r;
    audio_valid = 1'b1;
    @(negedge clk);
    audio_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] word;
    logic [23:0] l5, r5;

    // Reset state
    #12;
    check("rst_sclk",  64'(i2s_sclk),   64'd0);
    check("rst_lrclk", 64'(i2s_lrclk),  64'd0);
    check("rst_dout",  64'(i2s_dout),   64'd0);
    check("rst_fload", 64'(frame_load), 64'd0);
    check("rst_stale", 64'(stale),      64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Divider / frame timing
    wait_cycle(1);   check("t_sclk_c1",   64'(i2s_sclk),   64'd0);
    wait_cycle(2);   check("t_sclk_c2",   64'(i2s_sclk),   64'd1);
    wait_cycle(4);   check("t_sclk_c4",   64'(i2s_sclk),   64'd0);
    wait_cycle(127); check("t_lr_c127",   64'(i2s_lrclk),  64'd0);
    wait_cycle(128); check("t_lr_c128",   64'(i2s_lrclk),  64'd1);
    wait_cycle(255); check("t_fl_c255",   64'(frame_load), 64'd0);
    wait_cycle(256); check("t_fl_c256",   64'(frame_load), 64'd1);
    check("t_stale_c256", 64'(stale), 64'd1);
    check("t_lr_c256",    64'(i2s_lrclk), 64'd0);

    // Serial format: decode on SCLK rising edges after the load at 512
    wait_cycle(300);
    strobe(24'h800001, 24'h7FFFFE);
    wait_cycle(512);
    check("fmt_stale", 64'(stale), 64'd0);
    word = '0;
    for (int j = 1; j <= 64; j++) begin
      wait_cycle(512 + 4 * j + 2);
      word[64 - j] = i2s_dout;
    end
    check("fmt_word", word, 64'h800001_00_7FFFFE_00);

    // Decimation: five pairs in frame 768..1023, only the last is sent
    for (int p = 0; p < 5; p++) begin
      wait_cycle(800 + 20 * p);
      l5 = 24'($urandom); r5 = 24'($urandom);
      strobe(l5, r5);
    end
    wait_cycle(1024); check("dec_stale_fresh", 64'(stale), 64'd0);
    wait_cycle(1280); check("dec_stale_rep",   64'(stale), 64'd1);

    // Collision: strobe exactly on the load edge 1536
    wait_cycle(1535);
    strobe(24'h123456, 24'h123456);
    check("col_stale_now",  64'(stale), 64'd1);
    wait_cycle(1792); check("col_stale_next", 64'(stale), 64'd0);

    // Mute at load 2048 with a fresh non-zero pair held
    wait_cycle(1900);
    strobe(24'hABCDEF, 24'h654321);
    wait_cycle(2047);
    mute = 1'b1;
    wait_cycle(2048);
    mute = 1'b0;
    check("mute_stale",  64'(stale), 64'd0);
    wait_cycle(2304); check("unmute_stale", 64'(stale), 64'd1);

    // Randomised traffic
    for (int c = 2305; c < 4096; c++) begin
      wait_cycle(c);
      audio.left  = 24'($urandom);
      audio.right = 24'($urandom);
      audio_valid = ($urandom_range(0, 7) == 0);
      mute        = ($urandom_range(0, 3) == 0);
    end
    audio_valid = 1'b0;
    mute = 1'b0;

    // Reset mid-frame at bit_cnt = 40 of frame starting at 4352
    wait_cycle(4512);
    check("pre_rst_lrclk", 64'(i2s_lrclk), 64'd1);
    check("pre_rst_stale", 64'(stale),     64'd1);
    check("pre_rst_sclk",  64'(i2s_sclk),  64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_sclk",  64'(i2s_sclk),   64'd0);
    check("arst_lrclk", 64'(i2s_lrclk),  64'd0);
    check("arst_dout",  64'(i2s_dout),   64'd0);
    check("arst_stale", 64'(stale),      64'd0);
    check("arst_fload", 64'(frame_load), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_cycle(256);
    check("post_rst_fload", 64'(frame_load), 64'd1);
    check("post_rst_stale", 64'(stale),      64'd1);
    wait_cycle(520);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
